// File: rtl/msix_table.sv
// msix_table: MSI-X vector table and pending bit array behind a BAR window, with
// trigger arbitration against enable, function mask and per-vector mask.
module msix_table #(
  parameter int          NUM_MSIX          = 8,
  parameter int          MSIX_TABLE_BIR    = 0,
  parameter logic [31:0] MSIX_TABLE_OFFSET = 32'h2000,
  parameter int          MSIX_PBA_BIR      = 0,
  parameter logic [31:0] MSIX_PBA_OFFSET   = 32'h3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bar_addr,
  input  logic [2:0]  bar_index,
  input  logic [31:0] bar_wr_data,
  input  logic        bar_wr_en,
  input  logic [3:0]  bar_wr_be,
  input  logic        bar_rd_en,
  output logic [31:0] bar_rd_data,
  output logic        bar_access_match,
  input  logic        msix_enable,
  input  logic        msix_function_mask,
  output logic        msix_interrupt,
  output logic [10:0] msix_vector,
  input  logic        msix_interrupt_ack
);
  localparam int IW   = NUM_MSIX > 1 ? $clog2(NUM_MSIX) : 1;
  localparam int PBAN = (NUM_MSIX + 31) / 32;
  localparam int PW   = PBAN > 1 ? $clog2(PBAN) : 1;
  // Simulation-level event source: request is seen at exactly one posedge.
  logic        trig_valid  = 1'b0;
  logic [10:0] trig_vector = '0;
  task automatic trigger_interrupt(input logic [10:0] vector);
    @(negedge clk);
    trig_valid  = 1'b1;
    trig_vector = vector;
    @(negedge clk);
    trig_valid  = 1'b0;
  endtask
  logic [31:0]         addr_q [NUM_MSIX];
  logic [31:0]         data_q [NUM_MSIX];
  logic [31:0]         ctrl_q [NUM_MSIX];
  logic [NUM_MSIX-1:0] pend_q, pend_d;
  logic [32*PBAN-1:0]  pend_ext;
  logic [31:0]         rd_q, rd_d, tbl_rd, tbl_off, pba_off;
  logic                int_q, int_d, int_hold, trig_ok, deliver, table_hit, pba_hit;
  logic [10:0]         vec_q, vec_d;
  logic [IW-1:0]       ent, tidx;
  logic [1:0]          dw;
  logic [PW-1:0]       pw;
  assign tbl_off = bar_addr - MSIX_TABLE_OFFSET;
  assign pba_off = bar_addr - MSIX_PBA_OFFSET;
  assign table_hit = bar_index == 3'(MSIX_TABLE_BIR) && bar_addr >= MSIX_TABLE_OFFSET &&
                     tbl_off < 32'(16 * NUM_MSIX);
  assign pba_hit = bar_index == 3'(MSIX_PBA_BIR) && bar_addr >= MSIX_PBA_OFFSET &&
                   pba_off < 32'(4 * PBAN);
  assign bar_access_match = table_hit || pba_hit;
  assign ent = tbl_off[4 +: IW];
  assign dw  = tbl_off[3:2];
  assign pw  = pba_off[2 +: PW];
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_MSIX-1:0] = pend_q;
  end
  assign tbl_rd = dw == 2'd0 ? addr_q[ent] : dw == 2'd1 ? data_q[ent] : dw == 2'd2 ? ctrl_q[ent] : '0;
  assign rd_d = !bar_rd_en ? rd_q : table_hit ? tbl_rd : pba_hit ? pend_ext[32*pw +: 32] : '0;
  // Arbitration uses pre-edge mask/enable; a same-edge ack frees the slot.
  assign tidx     = trig_vector[IW-1:0];
  assign trig_ok  = trig_valid && msix_enable && {21'b0, trig_vector} < 32'(NUM_MSIX);
  assign int_hold = int_q && !msix_interrupt_ack;
  assign deliver  = trig_ok && !msix_function_mask && !ctrl_q[tidx][0] && !int_hold;
  assign int_d    = deliver || int_hold;
  assign vec_d    = deliver ? trig_vector : vec_q;
  always_comb begin
    pend_d = pend_q;
    if (trig_ok) pend_d[tidx] = !deliver;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      int_q  <= 1'b0;
      vec_q  <= '0;
      rd_q   <= '0;
      pend_q <= '0;
    end else begin
      int_q  <= int_d;
      vec_q  <= vec_d;
      rd_q   <= rd_d;
      pend_q <= pend_d;
    end
  for (genvar e = 0; e < NUM_MSIX; e++) begin : g_ent
    logic wr_hit;
    assign wr_hit = bar_wr_en && table_hit && ent == IW'(e);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        addr_q[e] <= '0;
        data_q[e] <= '0;
        ctrl_q[e] <= 32'h1;
      end else if (wr_hit) begin
        for (int b = 0; b < 4; b++)
          if (bar_wr_be[b]) begin
            if (dw == 2'd0) addr_q[e][8*b +: 8] <= bar_wr_data[8*b +: 8];
            if (dw == 2'd1) data_q[e][8*b +: 8] <= bar_wr_data[8*b +: 8];
            if (dw == 2'd2) ctrl_q[e][8*b +: 8] <= bar_wr_data[8*b +: 8];
          end
      end
  end
  assign bar_rd_data    = rd_q;
  assign msix_interrupt = int_q;
  assign msix_vector    = vec_q;
endmodule

// File: tb/tb_msix_table.sv
// tb_msix_table: directed checks of BAR access, trigger arbitration and reset.
module tb_msix_table;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bar_addr = '0;
  logic [2:0]  bar_index = '0;
  logic [31:0] bar_wr_data = '0;
  logic        bar_wr_en = 1'b0;
  logic [3:0]  bar_wr_be = '0;
  logic        bar_rd_en = 1'b0;
  logic [31:0] bar_rd_data;
  logic        bar_access_match;
  logic        msix_enable = 1'b0;
  logic        msix_function_mask = 1'b0;
  logic        msix_interrupt;
  logic [10:0] msix_vector;
  logic        msix_interrupt_ack = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] rd;
  logic        m;
  msix_table dut (
    .clk(clk), .reset(reset), .bar_addr(bar_addr), .bar_index(bar_index),
    .bar_wr_data(bar_wr_data), .bar_wr_en(bar_wr_en), .bar_wr_be(bar_wr_be),
    .bar_rd_en(bar_rd_en), .bar_rd_data(bar_rd_data), .bar_access_match(bar_access_match),
    .msix_enable(msix_enable), .msix_function_mask(msix_function_mask),
    .msix_interrupt(msix_interrupt), .msix_vector(msix_vector),
    .msix_interrupt_ack(msix_interrupt_ack)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic bar_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bar_addr = a;
    bar_wr_data = d;
    bar_wr_be = be;
    bar_wr_en = 1'b1;
    @(negedge clk);
    bar_wr_en = 1'b0;
  endtask
  task automatic bar_read(input logic [31:0] a, output logic [31:0] d, output logic match);
    @(negedge clk);
    bar_addr = a;
    bar_rd_en = 1'b1;
    #1 match = bar_access_match;
    @(negedge clk);
    bar_rd_en = 1'b0;
    d = bar_rd_data;
  endtask
  task automatic ack;
    @(negedge clk);
    msix_interrupt_ack = 1'b1;
    @(negedge clk);
    msix_interrupt_ack = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_int", 32'(msix_interrupt), 32'h0);
    check("rst_vec", 32'(msix_vector), 32'h0);
    check("rst_rd", bar_rd_data, 32'h0);
    reset = 1'b0;
    bar_write(32'h2000, 32'hFEDCBA98, 4'hF);
    bar_write(32'h2004, 32'h12345678, 4'hF);
    bar_write(32'h2008, 32'h0, 4'hF);
    bar_read(32'h2000, rd, m); check("rd_addr", rd, 32'hFEDCBA98); check("match_addr", 32'(m), 32'h1);
    bar_read(32'h2004, rd, m); check("rd_data", rd, 32'h12345678); check("match_data", 32'(m), 32'h1);
    bar_read(32'h2008, rd, m); check("rd_ctrl", rd, 32'h0); check("match_ctrl", 32'(m), 32'h1);
    bar_read(32'h2028, rd, m); check("rst_ctrl2", rd, 32'h1);
    bar_read(32'h3000, rd, m); check("pba_init", rd, 32'h0); check("match_pba", 32'(m), 32'h1);
    msix_enable = 1'b1;
    dut.trigger_interrupt(11'd0);
    check("deliver0_int", 32'(msix_interrupt), 32'h1);
    check("deliver0_vec", 32'(msix_vector), 32'h0);
    ack;
    check("ack_int", 32'(msix_interrupt), 32'h0);
    bar_write(32'h2008, 32'h1, 4'hF);
    dut.trigger_interrupt(11'd0);
    check("masked_int", 32'(msix_interrupt), 32'h0);
    bar_read(32'h3000, rd, m); check("masked_pba", rd, 32'h1);
    bar_write(32'h2008, 32'h0, 4'hF);
    msix_function_mask = 1'b1;
    dut.trigger_interrupt(11'd0);
    check("fmask_int", 32'(msix_interrupt), 32'h0);
    bar_read(32'h3000, rd, m); check("fmask_pba", rd, 32'h1);
    msix_function_mask = 1'b0;
    dut.trigger_interrupt(11'd0);
    check("unmask_int", 32'(msix_interrupt), 32'h1);
    bar_read(32'h3000, rd, m); check("unmask_pba", rd, 32'h0);
    bar_write(32'h2018, 32'h0, 4'hF);
    dut.trigger_interrupt(11'd1);
    check("busy_int", 32'(msix_interrupt), 32'h1);
    check("busy_vec", 32'(msix_vector), 32'h0);
    bar_read(32'h3000, rd, m); check("busy_pba", rd, 32'h2);
    fork
      dut.trigger_interrupt(11'd1);
      ack;
    join
    check("ackdel_int", 32'(msix_interrupt), 32'h1);
    check("ackdel_vec", 32'(msix_vector), 32'h1);
    bar_read(32'h3000, rd, m); check("ackdel_pba", rd, 32'h0);
    ack;
    check("ack2_vec", 32'(msix_vector), 32'h1);
    bar_write(32'h2010, 32'hAABBCCDD, 4'b0010);
    bar_read(32'h2010, rd, m); check("be_write", rd, 32'h0000CC00);
    bar_write(32'h200C, 32'hFFFFFFFF, 4'hF);
    bar_read(32'h200C, rd, m); check("dw3_zero", rd, 32'h0);
    bar_read(32'h2080, rd, m); check("oor_rd", rd, 32'h0); check("oor_match", 32'(m), 32'h0);
    dut.trigger_interrupt(11'd9);
    check("oor_trig", 32'(msix_interrupt), 32'h0);
    bar_write(32'h2038, 32'h0, 4'hF);
    msix_enable = 1'b0;
    dut.trigger_interrupt(11'd3);
    check("dis_int", 32'(msix_interrupt), 32'h0);
    bar_read(32'h3000, rd, m); check("dis_pba", rd, 32'h0);
    msix_enable = 1'b1;
    dut.trigger_interrupt(11'd3);
    check("en3_int", 32'(msix_interrupt), 32'h1);
    check("en3_vec", 32'(msix_vector), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("arst_int", 32'(msix_interrupt), 32'h0);
    check("arst_vec", 32'(msix_vector), 32'h0);
    check("arst_rd", bar_rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bar_read(32'h2000, rd, m); check("arst_addr", rd, 32'h0);
    bar_read(32'h2038, rd, m); check("arst_ctrl3", rd, 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/msix_table.md
# msix_table

MSI-X capability backing store for a PCIe endpoint BAR. Holds `NUM_MSIX` table entries (message address, message data, vector control) plus the Pending Bit Array (PBA), both mapped into a BAR at configurable offsets. It decodes BAR reads and writes and arbitrates interrupt triggers against the MSI-X enable, function mask and per-vector mask. It presents one outstanding interrupt to the downstream message generator, which acknowledges it.

## Interface
Parameters:
- `NUM_MSIX`, 8: number of vectors, 1..2048.
- `MSIX_TABLE_BIR`, 0: BAR index holding the table.
- `MSIX_TABLE_OFFSET`, 32'h2000: byte offset of the table within that BAR.
- `MSIX_PBA_BIR`, 0: BAR index holding the PBA.
- `MSIX_PBA_OFFSET`, 32'h3000: byte offset of the PBA within that BAR.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `bar_addr`  in  32  BAR-relative byte address.
- `bar_index`  in  3  BAR being accessed.
- `bar_wr_data`  in  32  write data.
- `bar_wr_en`  in  1  write strobe, one cycle per write.
- `bar_wr_be`  in  4  byte enables.
- `bar_rd_en`  in  1  read strobe.
- `bar_rd_data`  out  32  registered read data.
- `bar_access_match`  out  1  combinational flag: the address hits the table or the PBA.
- `msix_enable`  in  1  MSI-X Enable bit from config space.
- `msix_function_mask`  in  1  Function Mask bit.
- `msix_interrupt`  out  1  interrupt request, level, held until acknowledged.
- `msix_vector`  out  11  vector number of the current or last request.
- `msix_interrupt_ack`  in  1  one-cycle acknowledge.

Task `trigger_interrupt(input [10:0] vector)`: the behavioural trigger hook used by benches and the simulation-level event source. It waits for a `negedge clk`, drives an internal request (valid flag plus vector) high, then waits for the next `negedge` and drops it. The request is therefore seen at exactly one `posedge`.

## Operation
- **Table hit:** `bar_index==MSIX_TABLE_BIR` and `MSIX_TABLE_OFFSET <= bar_addr < MSIX_TABLE_OFFSET+16*NUM_MSIX`.
- **PBA hit:** `bar_index==MSIX_PBA_BIR` and `MSIX_PBA_OFFSET <= bar_addr < MSIX_PBA_OFFSET+4*ceil(NUM_MSIX/32)`.
- `bar_access_match` is the OR of the table hit and the PBA hit.
- **Entry layout:** entry n sits at table offset 16n. `bar_addr[1:0]` is ignored.
  - DW0 = message address, RW.
  - DW1 = message data, RW.
  - DW2 = vector control, RW all 32 bits; bit0 is the vector mask.
  - DW3 is reserved: reads 0, writes are ignored.
- **Writes:** apply only on a table hit, per byte via `bar_wr_be`. PBA writes and non-matching writes are ignored.
- **Reads:** PBA dword k returns pending[32k+31:32k]. Bits at or above `NUM_MSIX` read 0. Non-matching reads return 0.
- **Trigger for vector v** (v < `NUM_MSIX`; out-of-range v is ignored):
  - If `msix_enable` is 0, the trigger is dropped.
  - Delivered when `msix_function_mask`=0, mask[v]=0 and `msix_interrupt`=0 (after same-cycle ack). Delivery sets `msix_interrupt`=1, sets `msix_vector`=v and clears pending[v].
  - Otherwise pending[v] is set.
- Pending bits are never auto-delivered on unmask. They are delivered or cleared only by a later deliverable trigger of the same vector.
- **Acknowledge:** `msix_interrupt_ack`=1 clears `msix_interrupt`. `msix_vector` holds its value.

## Timing
- Reset values:
  - `msix_interrupt`=0, `msix_vector`=0, `bar_rd_data`=0, all pending bits 0.
  - Address and data = 0 for every entry.
  - Vector control = 32'h1, so every vector resets masked.
- Writes take effect at the `posedge` where `bar_wr_en` is 1.
- Reads: `bar_rd_data` is loaded at the `posedge` where `bar_rd_en` is 1, so it is valid one cycle after the request. It holds until the next read.
- A read and a write to the same address in the same cycle returns the old data.
- A trigger sampled at a `posedge` asserts `msix_interrupt` at that same edge. Mask and enable values are those before any same-edge write.
- Ack and a deliverable trigger at the same edge: the new request is issued and `msix_interrupt` stays 1 with the new vector.
- A trigger while `msix_interrupt`=1 with no ack sets pending[v].
- Reset mid-operation clears the state asynchronously. Any request in flight is lost.

## Test plan
- Write 0xFEDCBA98, 0x12345678, 0x0 to 0x2000, 0x2004, 0x2008 (be=F). Reading the same addresses returns the same values one cycle later, and `bar_access_match`=1.
- `msix_enable`=1, entry0 unmasked, trigger(0) -> `msix_interrupt`=1 and `msix_vector`=0. Then ack for one cycle -> `msix_interrupt`=0.
- Write 0x1 to 0x2008, trigger(0) -> `msix_interrupt` stays 0 and reading 0x3000 returns bit0=1.
- Write 0x0 to 0x2008, set `msix_function_mask`=1, trigger(0) -> no interrupt and PBA bit0=1. Then clear the function mask and trigger(0) -> interrupt asserted and PBA bit0=0.
- Byte-enable write of be=4'b0010 with data 0xAABBCCDD to 0x2010 over 0 -> reads 0x0000CC00. A read at 0x2080 (out of range) returns 0 with `bar_access_match`=0.
- `msix_enable`=0, trigger(3) -> no interrupt and PBA unchanged. Assert `reset` mid-interrupt -> all outputs return to reset values.
